ysyx_23060278_mcore: RTL and testbench

Parametrised multi-cycle successor to the single-cycle NPC top. It fetches over a valid/ready instruction bus instead of taking `inst` combinationally, so it tolerates variable memory latency. It executes an RV32I/RV32E subset through a FETCH/WAIT/EXEC state machine and publishes a one-cycle commit record per retired instruction for the difftest/trace harness.

---
 rtl/ysyx_23060278_pkg.sv | 47 ++++
 rtl/ysyx_23060278_gpr.sv | 35 +++
 rtl/ysyx_23060278_mcore.sv | 238 +++++++++++++++++++++++
 tb/tb_ysyx_23060278_mcore.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060278_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, function codes,
// FSM states, immediate formats and the immediate generator.
package ysyx_23060278_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_U = 2'd1,
        IMM_J = 2'd2
    } imm_type_e;

    // Sign-extended / shifted immediate for the given instruction format.
    function automatic logic [31:0] gen_imm(input imm_type_e sel, input logic [31:0] inst);
        logic [31:0] imm;
        imm = 32'd0;
        case (sel)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_U:   imm = {inst[31:12], 12'd0};
            IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ysyx_23060278_gpr.sv
// General purpose register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, synchronous clear on reset.
module ysyx_23060278_gpr #(
    parameter int NR_REGS = 32,
    parameter int XLEN    = 32,
    localparam int AW     = $clog2(NR_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] regs_r [NR_REGS];

    // Register storage: cleared on reset, writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (rd_addr != {AW{1'b0}})) begin
            regs_r[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[rs2_addr];

endmodule

// File: rtl/ysyx_23060278_mcore.sv
// Multi-cycle RV32I/RV32E subset core. Fetches over a valid/ready bus,
// executes in a FETCH/WAIT/EXEC sequence and emits a one-cycle commit record
// per retired instruction. ebreak or an unsupported encoding parks it in HALT.
module ysyx_23060278_mcore
    import ysyx_23060278_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NR_REGS  = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    input  logic [31:0]     ifu_rsp_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] snxt_pc,
    output logic [XLEN-1:0] dnxt_pc,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    output logic            halt,
    output logic            illegal
);

    localparam int AW = $clog2(NR_REGS);

    if (XLEN != 32) begin : g_xlen_chk
        $error("ysyx_23060278_mcore: only XLEN = 32 is supported");
    end
    if ((NR_REGS != 32) && (NR_REGS != 16)) begin : g_nregs_chk
        $error("ysyx_23060278_mcore: NR_REGS must be 16 or 32");
    end

    state_e      state_r, state_nxt_s;
    logic [31:0] pc_r, inst_r;
    logic        commit_valid_r, halt_r, illegal_r;
    logic [31:0] commit_pc_r, commit_inst_r;

    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_idx_s, rs1_idx_s, rs2_idx_s;
    imm_type_e   imm_type_s;
    logic [31:0] imm_s, rs1_data_s, rs2_data_s, jalr_sum_s, seq_pc_s;
    logic        dec_legal_s, ebreak_s, wb_en_s, jump_s, use_rs1_s, use_rs2_s;
    logic [31:0] wb_data_s, jump_tgt_s;
    logic        reg_ok_s, legal_s, halt_go_s, gpr_we_s;

    assign opcode_s  = inst_r[6:0];
    assign rd_idx_s  = inst_r[11:7];
    assign funct3_s  = inst_r[14:12];
    assign rs1_idx_s = inst_r[19:15];
    assign rs2_idx_s = inst_r[24:20];
    assign funct7_s  = inst_r[31:25];

    // Immediate format selection from the opcode alone
    always_comb begin
        imm_type_s = IMM_I;
        case (opcode_s)
            LUI, AUIPC: imm_type_s = IMM_U;
            JAL:        imm_type_s = IMM_J;
            default:    imm_type_s = IMM_I;
        endcase
    end

    assign imm_s      = gen_imm(imm_type_s, inst_r);
    assign seq_pc_s   = pc_r + 32'd4;
    assign jalr_sum_s = rs1_data_s + imm_s;

    // Decode, ALU and jump target for the latched instruction
    always_comb begin
        dec_legal_s = 1'b0;
        ebreak_s    = 1'b0;
        wb_en_s     = 1'b0;
        wb_data_s   = 32'd0;
        jump_s      = 1'b0;
        jump_tgt_s  = 32'd0;
        use_rs1_s   = 1'b0;
        use_rs2_s   = 1'b0;
        case (opcode_s)
            OP_IMM: begin
                if (funct3_s == F3_ADDI) begin
                    dec_legal_s = 1'b1;
                    wb_en_s     = 1'b1;
                    use_rs1_s   = 1'b1;
                    wb_data_s   = rs1_data_s + imm_s;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            OP: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                if ((funct3_s == F3_ADD_SUB) && (funct7_s == F7_ADD)) begin
                    dec_legal_s = 1'b1;
                    wb_en_s     = 1'b1;
                    wb_data_s   = rs1_data_s + rs2_data_s;
                end else if ((funct3_s == F3_ADD_SUB) && (funct7_s == F7_SUB)) begin
                    dec_legal_s = 1'b1;
                    wb_en_s     = 1'b1;
                    wb_data_s   = rs1_data_s - rs2_data_s;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            LUI: begin
                dec_legal_s = 1'b1;
                wb_en_s     = 1'b1;
                wb_data_s   = imm_s;
            end
            AUIPC: begin
                dec_legal_s = 1'b1;
                wb_en_s     = 1'b1;
                wb_data_s   = pc_r + imm_s;
            end
            JAL: begin
                dec_legal_s = 1'b1;
                wb_en_s     = 1'b1;
                wb_data_s   = seq_pc_s;
                jump_s      = 1'b1;
                jump_tgt_s  = pc_r + imm_s;
            end
            JALR: begin
                if (funct3_s == F3_JALR) begin
                    dec_legal_s = 1'b1;
                    wb_en_s     = 1'b1;
                    use_rs1_s   = 1'b1;
                    wb_data_s   = seq_pc_s;
                    jump_s      = 1'b1;
                    jump_tgt_s  = {jalr_sum_s[31:1], 1'b0};
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            SYSTEM: begin
                if (inst_r == EBREAK_INST) begin
                    dec_legal_s = 1'b1;
                    ebreak_s    = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // RV32E has only x0..x15; any referenced register index with bit 4 set is illegal
    assign reg_ok_s  = (NR_REGS != 16) ||
                       !((wb_en_s && rd_idx_s[4]) || (use_rs1_s && rs1_idx_s[4]) ||
                         (use_rs2_s && rs2_idx_s[4]));
    assign legal_s   = dec_legal_s & reg_ok_s;
    assign halt_go_s = ebreak_s | ~legal_s;
    assign gpr_we_s  = (state_r == ST_EXEC) & wb_en_s & legal_s;

    ysyx_23060278_gpr #(
        .NR_REGS (NR_REGS),
        .XLEN    (XLEN)
    ) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_idx_s[AW-1:0]),
        .rs1_data (rs1_data_s),
        .rs2_addr (rs2_idx_s[AW-1:0]),
        .rs2_data (rs2_data_s),
        .we       (gpr_we_s),
        .rd_addr  (rd_idx_s[AW-1:0]),
        .rd_data  (wb_data_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: state_nxt_s = ifu_req_ready ? ST_WAIT : ST_FETCH;
            ST_WAIT:  state_nxt_s = ifu_rsp_valid ? ST_EXEC : ST_WAIT;
            ST_EXEC:  state_nxt_s = halt_go_s ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nxt_s = ST_HALT;
            default:  state_nxt_s = ST_FETCH;
        endcase
    end

    // Instruction latch, PC update, commit record and sticky halt flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r           <= RESET_PC;
            inst_r         <= 32'd0;
            commit_valid_r <= 1'b0;
            commit_pc_r    <= 32'd0;
            commit_inst_r  <= 32'd0;
            halt_r         <= 1'b0;
            illegal_r      <= 1'b0;
        end else begin
            commit_valid_r <= 1'b0;
            case (state_r)
                ST_WAIT: begin
                    if (ifu_rsp_valid) begin
                        inst_r <= ifu_rsp_data;
                    end
                end
                ST_EXEC: begin
                    commit_valid_r <= 1'b1;
                    commit_pc_r    <= pc_r;
                    commit_inst_r  <= inst_r;
                    if (halt_go_s) begin
                        halt_r    <= 1'b1;
                        illegal_r <= ~legal_s;
                    end else begin
                        pc_r <= dnxt_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ifu_req_valid = (state_r == ST_FETCH) && !rst;
    assign ifu_req_addr  = pc_r;
    assign pc            = pc_r;
    assign snxt_pc       = seq_pc_s;
    assign dnxt_pc       = ((state_r == ST_EXEC) && jump_s) ? jump_tgt_s : seq_pc_s;
    assign commit_valid  = commit_valid_r;
    assign commit_pc     = commit_pc_r;
    assign commit_inst   = commit_inst_r;
    assign halt          = halt_r;
    assign illegal       = illegal_r;

endmodule

// File: tb/tb_ysyx_23060278_mcore.sv
// Directed bench for the multi-cycle core: small instruction memory with
// configurable back-pressure, commit monitor and hand-computed expectations.
module tb_ysyx_23060278_mcore;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_data;
    logic [31:0] pc, snxt_pc, dnxt_pc, commit_pc, commit_inst;
    logic        commit_valid, halt, illegal;

    logic        e_req_valid, e_req_ready, e_rsp_valid;
    logic [31:0] e_req_addr, e_rsp_data;
    logic [31:0] e_pc, e_snxt_pc, e_dnxt_pc, e_commit_pc, e_commit_inst;
    logic        e_commit_valid, e_halt, e_illegal;

    int          n_checks, n_errors, cyc, t0;
    int          stall_left, rsp_delay, wait_cnt;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] mem [64];
    int          cm_cyc_q[$];
    logic [31:0] cm_pc_q[$], cm_inst_q[$];
    logic [1:0]  cm_flags_q[$];

    ysyx_23060278_mcore dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .pc(pc), .snxt_pc(snxt_pc), .dnxt_pc(dnxt_pc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .halt(halt), .illegal(illegal)
    );

    ysyx_23060278_mcore #(.NR_REGS(16)) dut_e (
        .clk(clk), .rst(rst),
        .ifu_req_valid(e_req_valid), .ifu_req_ready(e_req_ready), .ifu_req_addr(e_req_addr),
        .ifu_rsp_valid(e_rsp_valid), .ifu_rsp_data(e_rsp_data),
        .pc(e_pc), .snxt_pc(e_snxt_pc), .dnxt_pc(e_dnxt_pc),
        .commit_valid(e_commit_valid), .commit_pc(e_commit_pc), .commit_inst(e_commit_inst),
        .halt(e_halt), .illegal(e_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Commit monitor
    always @(negedge clk) begin
        if (commit_valid) begin
            cm_cyc_q.push_back(cyc);
            cm_pc_q.push_back(commit_pc);
            cm_inst_q.push_back(commit_inst);
            cm_flags_q.push_back({halt, illegal});
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        logic [31:0] w;
        if (addr[31:8] == 24'h800000) w = mem[addr[7:2]];
        else w = 32'hFFFF_FFFF;
        return w;
    endfunction

    // Instruction memory: optional request stall, optional extra response delay
    initial begin
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'd0;
        pend = 1'b0; pend_addr = 32'd0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            ifu_rsp_valid = 1'b0;
            ifu_rsp_data  = 32'd0;
            if (rst) begin
                pend = 1'b0;
                ifu_req_ready = 1'b0;
            end else begin
                if (pend) begin
                    if (wait_cnt == 0) begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rsp_data  = mem_rd(pend_addr);
                        pend = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (ifu_req_valid) begin
                    if (stall_left > 0) begin
                        ifu_req_ready = 1'b0;
                        stall_left--;
                    end else begin
                        ifu_req_ready = 1'b1;
                        pend = 1'b1;
                        pend_addr = ifu_req_addr;
                        wait_cnt = rsp_delay;
                        rsp_delay = 0;
                    end
                end else begin
                    ifu_req_ready = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        t0 = cyc;
        cm_cyc_q.delete(); cm_pc_q.delete(); cm_inst_q.delete(); cm_flags_q.delete();
        #1;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halt && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(halt), 32'd1);
        tick();
    endtask

    task automatic load_prog1();
        mem[0] = 32'h0050_0093;  // addi x1,x0,5
        mem[1] = 32'hFFD0_8113;  // addi x2,x1,-3
        mem[2] = 32'h0010_0073;  // ebreak
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; t0 = 0;
        stall_left = 0; rsp_delay = 0;
        e_req_ready = 1'b1; e_rsp_valid = 1'b1; e_rsp_data = 32'h0010_0813;  // addi x16,x0,1

        // Reset state
        hold_reset();
        chk("rst_pc", pc, RST_PC);
        chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_commit_pc", commit_pc, 32'd0);
        chk("rst_commit_inst", commit_inst, 32'd0);
        chk("rst_snxt_pc", snxt_pc, 32'h8000_0004);
        chk("rst_dnxt_pc", dnxt_pc, 32'h8000_0004);
        chk("rst_x1", dut.u_gpr.regs_r[1], 32'd0);

        // Test 1: basic addi sequence, minimum latency
        load_prog1();
        release_reset();
        chk("t1_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("t1_req_addr", ifu_req_addr, RST_PC);
        wait_halt("t1_halt");
        chk("t1_ncommit", 32'(cm_cyc_q.size()), 32'd3);
        chk("t1_c0_cyc", 32'(cm_cyc_q[0] - t0), 32'd3);
        chk("t1_c1_cyc", 32'(cm_cyc_q[1] - t0), 32'd6);
        chk("t1_c2_cyc", 32'(cm_cyc_q[2] - t0), 32'd9);
        chk("t1_c0_pc", cm_pc_q[0], 32'h8000_0000);
        chk("t1_c0_inst", cm_inst_q[0], 32'h0050_0093);
        chk("t1_c2_inst", cm_inst_q[2], 32'h0010_0073);
        chk("t1_c2_flags", 32'(cm_flags_q[2]), 32'd2);
        chk("t1_x1", dut.u_gpr.regs_r[1], 32'd5);
        chk("t1_x2", dut.u_gpr.regs_r[2], 32'd2);
        chk("t1_illegal", 32'(illegal), 32'd0);
        chk("t1_pc", pc, 32'h8000_0008);

        // Test 2: lui/jalr/auipc/jal/sub/add
        hold_reset();
        mem[0] = 32'h8000_02B7;  // lui x5,0x80000
        mem[1] = 32'h0102_80E7;  // jalr x1,0x10(x5)
        mem[4] = 32'h0000_1197;  // auipc x3,1
        mem[5] = 32'h0080_03EF;  // jal x7,+8
        mem[7] = 32'h4051_8433;  // sub x8,x3,x5
        mem[8] = 32'h0034_04B3;  // add x9,x8,x3
        mem[9] = 32'h0010_0073;  // ebreak
        release_reset();
        wait_halt("t2_halt");
        chk("t2_illegal", 32'(illegal), 32'd0);
        chk("t2_x5", dut.u_gpr.regs_r[5], 32'h8000_0000);
        chk("t2_x1", dut.u_gpr.regs_r[1], 32'h8000_0008);
        chk("t2_c2_pc", cm_pc_q[2], 32'h8000_0010);
        chk("t2_x3", dut.u_gpr.regs_r[3], 32'h8000_1010);
        chk("t2_x7", dut.u_gpr.regs_r[7], 32'h8000_0018);
        chk("t2_x8", dut.u_gpr.regs_r[8], 32'h0000_1010);
        chk("t2_x9", dut.u_gpr.regs_r[9], 32'h8000_2020);
        chk("t2_pc", pc, 32'h8000_0024);

        // Test 3: back-pressure on request and response
        hold_reset();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0073;
        stall_left = 4;
        rsp_delay = 2;
        release_reset();
        begin
            logic stable;
            stable = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (!(ifu_req_valid && (ifu_req_addr == RST_PC))) stable = 1'b0;
            end
            chk("t3_req_stable", 32'(stable), 32'd1);
        end
        wait_halt("t3_halt");
        chk("t3_ncommit", 32'(cm_cyc_q.size()), 32'd2);
        chk("t3_c0_cyc", 32'(cm_cyc_q[0] - t0), 32'd9);
        chk("t3_c1_cyc", 32'(cm_cyc_q[1] - t0), 32'd12);
        chk("t3_x1", dut.u_gpr.regs_r[1], 32'd5);

        // Test 4: x0 writes dropped, illegal encoding halts
        hold_reset();
        mem[0] = 32'h0070_0013;  // addi x0,x0,7
        mem[1] = 32'h0010_0313;  // addi x6,x0,1
        mem[2] = 32'hFFFF_FFFF;
        release_reset();
        wait_halt("t4_halt");
        chk("t4_x0", dut.u_gpr.regs_r[0], 32'd0);
        chk("t4_x6", dut.u_gpr.regs_r[6], 32'd1);
        chk("t4_ncommit", 32'(cm_cyc_q.size()), 32'd3);
        chk("t4_c2_pc", cm_pc_q[2], 32'h8000_0008);
        chk("t4_c2_inst", cm_inst_q[2], 32'hFFFF_FFFF);
        chk("t4_c2_flags", 32'(cm_flags_q[2]), 32'd3);
        begin
            logic quiet;
            quiet = 1'b1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (ifu_req_valid || commit_valid) quiet = 1'b0;
            end
            chk("t4_quiet", 32'(quiet), 32'd1);
        end
        chk("t4_pc", pc, 32'h8000_0008);
        chk("t4_illegal", 32'(illegal), 32'd1);

        // Test 5: reset while in HALT, then while in WAIT
        hold_reset();
        load_prog1();
        release_reset();
        wait_halt("t5_halt_a");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5h_pc", pc, RST_PC);
        chk("t5h_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("t5h_halt", 32'(halt), 32'd0);
        chk("t5h_x1", dut.u_gpr.regs_r[1], 32'd0);
        tick();
        chk("t5_in_wait_valid", 32'(ifu_req_valid), 32'd0);
        rst = 1'b1;
        tick();
        release_reset();
        chk("t5w_pc", pc, RST_PC);
        chk("t5w_req_valid", 32'(ifu_req_valid), 32'd1);
        wait_halt("t5_halt_b");
        chk("t5_ncommit", 32'(cm_cyc_q.size()), 32'd3);
        chk("t5_x2", dut.u_gpr.regs_r[2], 32'd2);

        // Test 6: RV32E build rejects x16
        chk("t6_e_halt", 32'(e_halt), 32'd1);
        chk("t6_e_illegal", 32'(e_illegal), 32'd1);
        chk("t6_e_pc", e_pc, RST_PC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
